// File: rtl/uart_mmio_pkg.sv
// +-----------------------------------------------------------------------+
// | uart_mmio_pkg : shared constants for the UART MMIO controller         |
// | Revision      : 1.0                                                   |
// +-----------------------------------------------------------------------+
`default_nettype none

package uart_mmio_pkg;

  localparam logic [3:0] IO_BASE          = 4'h8;

  localparam logic [7:0] ADDR_TX_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_RX_CTRL     = 8'h04;
  localparam logic [7:0] ADDR_RX_DATA     = 8'h08;
  localparam logic [7:0] ADDR_TX_DATA     = 8'h0C;
  localparam logic [7:0] ADDR_CYCLE       = 8'h10;
  localparam logic [7:0] ADDR_INSTR       = 8'h14;
  localparam logic [7:0] ADDR_CNT_CLR     = 8'h18;

  localparam int         RX_DEPTH_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// +-----------------------------------------------------------------------+
// | uart_rx_fifo : power-of-two circular FIFO buffering received bytes    |
// | Revision     : 1.0                                                    |
// +-----------------------------------------------------------------------+
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int                AW      = $clog2(DEPTH);
  localparam logic [AW-1:0]     PTR_ONE = 1;
  localparam logic [AW:0]       CNT_ONE = 1;
  localparam logic [AW:0]       CNT_MAX = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             w_push, w_pop;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i  && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (w_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_mmio_ctrl.sv
// +-----------------------------------------------------------------------+
// | uart_mmio_ctrl : M-stage MMIO decode, UART TX/RX handshake, counters  |
// | Revision       : 1.0                                                  |
// +-----------------------------------------------------------------------+
`default_nettype none

module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int RX_DEPTH = RX_DEPTH_DEFAULT,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] addrM,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [31:0] wdataM,
  input  logic        instr_retire,
  output logic        io_sel,
  output logic [31:0] rdata,
  output logic        stall_req,
  output logic [7:0]  uart_din,
  output logic        uart_din_valid,
  input  logic        uart_din_ready,
  input  logic [7:0]  uart_dout,
  input  logic        uart_dout_valid,
  output logic        uart_dout_ready
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_full_q, tx_full_d;
  logic [CNT_W-1:0] cycle_q,   cycle_d;
  logic [CNT_W-1:0] instr_q,   instr_d;

  logic [7:0]       w_off;
  logic             w_rd, w_wr;
  logic             w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [7:0]       w_rx_head;
  logic             w_tx_store, w_tx_cap, w_cnt_clr;
  logic             w_unused_bits;

  // Only the offset byte and the TX byte lane are meaningful here.
  assign w_unused_bits = ^{addrM[27:8], wdataM[31:8]};

  assign io_sel     = (addrM[31:28] == IO_BASE) && (mem_re || mem_we);
  assign w_off      = addrM[7:0];
  assign w_rd       = io_sel && mem_re;
  assign w_wr       = io_sel && mem_we && !mem_re;

  assign uart_dout_ready = !w_rx_full && !reset;
  assign w_rx_push  = uart_dout_valid && uart_dout_ready;
  assign w_rx_pop   = w_rd && (w_off == ADDR_RX_DATA) && !stall && !w_rx_empty;

  // stall_req looks only at registered tx_full, so a same-cycle drain
  // never shortens the stall; the store lands the cycle after.
  assign w_tx_store = w_wr && (w_off == ADDR_TX_DATA);
  assign stall_req  = w_tx_store && tx_full_q;
  assign w_tx_cap   = w_tx_store && !tx_full_q && !stall;
  assign w_cnt_clr  = w_wr && (w_off == ADDR_CNT_CLR) && !stall;

  assign uart_din_valid = tx_full_q;
  assign uart_din       = tx_data_q;

  uart_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_rx_push),
    .din_i   (uart_dout),
    .pop_i   (w_rx_pop),
    .full_o  (w_rx_full),
    .empty_o (w_rx_empty),
    .head_o  (w_rx_head)
  );

  always_comb begin
    rdata = '0;
    if (w_rd) begin
      case (w_off)
        ADDR_TX_CTRL: rdata = {31'b0, !tx_full_q};
        ADDR_RX_CTRL: rdata = {31'b0, !w_rx_empty};
        ADDR_RX_DATA: if (!w_rx_empty) rdata = {24'b0, w_rx_head};
        ADDR_CYCLE:   rdata = 32'(cycle_q);
        ADDR_INSTR:   rdata = 32'(instr_q);
        default:      rdata = '0;
      endcase
    end
  end

  always_comb begin
    tx_data_d = tx_data_q;
    tx_full_d = tx_full_q;
    cycle_d   = cycle_q + CNT_ONE;
    instr_d   = instr_retire ? (instr_q + CNT_ONE) : instr_q;
    if (w_tx_cap) begin
      tx_data_d = wdataM[7:0];
      tx_full_d = 1'b1;
    end else if (tx_full_q && uart_din_ready) begin
      tx_full_d = 1'b0;
    end
    if (w_cnt_clr) begin
      cycle_d = '0;
      instr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data_q <= '0;
      tx_full_q <= 1'b0;
      cycle_q   <= '0;
      instr_q   <= '0;
    end else begin
      tx_data_q <= tx_data_d;
      tx_full_q <= tx_full_d;
      cycle_q   <= cycle_d;
      instr_q   <= instr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_mmio_ctrl.sv
// +-----------------------------------------------------------------------+
// | tb_uart_mmio_ctrl : scoreboard bench for uart_mmio_ctrl               |
// | Revision          : 1.0                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_uart_mmio_ctrl;
  import uart_mmio_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, mem_re, mem_we, instr_retire;
  logic [31:0] addrM, wdataM;
  logic        io_sel, stall_req;
  logic [31:0] rdata;
  logic [7:0]  uart_din, uart_dout;
  logic        uart_din_valid, uart_din_ready, uart_dout_valid, uart_dout_ready;

  always #5 clk = ~clk;

  // Narrow counters so the wrap boundary is reachable in a short run.
  uart_mmio_ctrl #(.RX_DEPTH(4), .CNT_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .addrM           (addrM),
    .mem_re          (mem_re),
    .mem_we          (mem_we),
    .wdataM          (wdataM),
    .instr_retire    (instr_retire),
    .io_sel          (io_sel),
    .rdata           (rdata),
    .stall_req       (stall_req),
    .uart_din        (uart_din),
    .uart_din_valid  (uart_din_valid),
    .uart_din_ready  (uart_din_ready),
    .uart_dout       (uart_dout),
    .uart_dout_valid (uart_dout_valid),
    .uart_dout_ready (uart_dout_ready)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rd_q [$];
  string       exp_nm_q [$];
  logic [7:0]  exp_tx_q [$];
  string       mon_nm;
  logic [31:0] mon_exp;
  logic [7:0]  mon_tx;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every I/O load and every TX handshake consumes one expectation.
  always @(negedge clk) begin
    if (io_sel && mem_re) begin
      if (exp_rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", rdata);
      end else begin
        mon_nm  = exp_nm_q.pop_front();
        mon_exp = exp_rd_q.pop_front();
        check(mon_nm, rdata, mon_exp);
      end
    end
    if (uart_din_valid && uart_din_ready) begin
      if (exp_tx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_tx: got 0x%02h expected no transfer", uart_din);
      end else begin
        mon_tx = exp_tx_q.pop_front();
        check("tx_byte", {24'b0, uart_din}, {24'b0, mon_tx});
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string nm);
    addrM  = {IO_BASE, 20'h0, off};
    mem_re = 1'b1;
    exp_rd_q.push_back(exp);
    exp_nm_q.push_back(nm);
    cyc();
    mem_re = 1'b0;
    addrM  = '0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] data);
    addrM  = {IO_BASE, 20'h0, off};
    wdataM = data;
    mem_we = 1'b1;
    cyc();
    mem_we = 1'b0;
    addrM  = '0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    uart_dout       = b;
    uart_dout_valid = 1'b1;
    cyc();
    uart_dout_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; mem_re = 1'b0; mem_we = 1'b0; instr_retire = 1'b0;
    addrM = '0; wdataM = '0; uart_din_ready = 1'b0; uart_dout = '0; uart_dout_valid = 1'b0;
    repeat (3) cyc();
    check("rst_dout_ready", uart_dout_ready, 0);
    check("rst_din_valid", uart_din_valid, 0);
    check("rst_stall_req", stall_req, 0);
    reset = 1'b0;

    // Reset state and idle counting
    repeat (10) cyc();
    rd(ADDR_CYCLE,   32'd10, "cycle_after_10");
    rd(ADDR_INSTR,   32'd0,  "instr_zero");
    rd(ADDR_RX_CTRL, 32'd0,  "rx_ctrl_empty");
    rd(ADDR_TX_CTRL, 32'd1,  "tx_ctrl_free");
    check("idle_din_valid", uart_din_valid, 0);
    check("idle_dout_ready", uart_dout_ready, 1);

    // Basic RX ordering and empty read
    send_rx(8'h41); send_rx(8'h42); send_rx(8'h43);
    rd(ADDR_RX_CTRL, 32'd1,    "rx_ctrl_avail");
    rd(ADDR_RX_DATA, 32'h41,   "rx_b0");
    rd(ADDR_RX_DATA, 32'h42,   "rx_b1");
    rd(ADDR_RX_DATA, 32'h43,   "rx_b2");
    rd(ADDR_RX_DATA, 32'h0,    "rx_empty_read");
    rd(ADDR_RX_CTRL, 32'd0,    "rx_ctrl_drained");

    // Non-I/O and stalled loads must not pop
    send_rx(8'h77);
    addrM = 32'h0000_0008; mem_re = 1'b1; #1;
    check("non_io_sel", io_sel, 0);
    cyc(); mem_re = 1'b0; addrM = '0;
    stall = 1'b1;
    rd(ADDR_RX_DATA, 32'h77, "rx_stalled_read");
    stall = 1'b0;
    rd(ADDR_RX_DATA, 32'h77, "rx_after_stall");
    rd(ADDR_RX_CTRL, 32'd0,  "rx_ctrl_after_stall");

    // Fill to capacity; pop frees a slot usable next cycle
    for (int i = 0; i < 4; i++) send_rx(8'h10 + 8'(i));
    check("full_ready_low", uart_dout_ready, 0);
    uart_dout = 8'h14; uart_dout_valid = 1'b1;
    rd(ADDR_RX_DATA, 32'h10, "full_pop");
    check("ready_after_pop", uart_dout_ready, 1);
    cyc();
    uart_dout_valid = 1'b0;
    rd(ADDR_RX_DATA, 32'h11, "fifo_b1");
    rd(ADDR_RX_DATA, 32'h12, "fifo_b2");
    rd(ADDR_RX_DATA, 32'h13, "fifo_b3");
    rd(ADDR_RX_DATA, 32'h14, "fifo_b4");
    rd(ADDR_RX_CTRL, 32'd0,  "fifo_drained");

    // Simultaneous push and pop while partially full
    send_rx(8'hA1);
    uart_dout = 8'hA2; uart_dout_valid = 1'b1;
    rd(ADDR_RX_DATA, 32'hA1, "pushpop_head");
    uart_dout_valid = 1'b0;
    rd(ADDR_RX_DATA, 32'hA2, "pushpop_next");
    rd(ADDR_RX_CTRL, 32'd0,  "pushpop_empty");

    // TX holding register and back-pressure stall
    exp_tx_q.push_back(8'h55);
    wr(ADDR_TX_DATA, 32'h0000_0055);
    check("tx_valid_held", uart_din_valid, 1);
    rd(ADDR_TX_CTRL, 32'd0, "tx_ctrl_full");
    addrM = {IO_BASE, 20'h0, ADDR_TX_DATA}; wdataM = 32'h0000_1266; mem_we = 1'b1; #1;
    check("stall_req_full", stall_req, 1);
    cyc();
    check("stall_req_still", stall_req, 1);
    uart_din_ready = 1'b1; #1;
    check("stall_req_not_ready_comb", stall_req, 1);
    cyc();
    uart_din_ready = 1'b0; #1;
    check("stall_req_dropped", stall_req, 0);
    exp_tx_q.push_back(8'h66);
    cyc();
    mem_we = 1'b0; addrM = '0;
    check("tx_valid_second", uart_din_valid, 1);
    uart_din_ready = 1'b1;
    cyc();
    uart_din_ready = 1'b0;
    rd(ADDR_TX_CTRL, 32'd1, "tx_ctrl_drained");

    // Counter clear with simultaneous retirement
    instr_retire = 1'b1; repeat (7) cyc(); instr_retire = 1'b0;
    rd(ADDR_INSTR, 32'd7, "instr_7");
    instr_retire = 1'b1;
    wr(ADDR_CNT_CLR, 32'hDEAD_BEEF);
    instr_retire = 1'b0;
    rd(ADDR_CYCLE, 32'd0, "cycle_cleared");
    rd(ADDR_INSTR, 32'd0, "instr_cleared");
    rd(ADDR_CYCLE, 32'd2, "cycle_resumed");
    instr_retire = 1'b1; repeat (2) cyc(); instr_retire = 1'b0;
    rd(ADDR_INSTR, 32'd2, "instr_resumed");
    stall = 1'b1;
    wr(ADDR_CNT_CLR, 32'h0);
    stall = 1'b0;
    rd(ADDR_INSTR, 32'd2, "clr_blocked_by_stall");

    // Counter wrap and unmapped offset
    wr(ADDR_CNT_CLR, 32'h0);
    repeat (255) cyc();
    rd(ADDR_CYCLE, 32'd255, "cycle_all_ones");
    rd(ADDR_CYCLE, 32'd0,   "cycle_wrapped");
    addrM = {IO_BASE, 20'h0, 8'h1C}; mem_re = 1'b1;
    exp_rd_q.push_back(32'h0); exp_nm_q.push_back("unmapped_read");
    #1;
    check("unmapped_io_sel", io_sel, 1);
    cyc(); mem_re = 1'b0; addrM = '0;

    // Reset mid-transfer discards TX byte and RX contents
    send_rx(8'h99);
    wr(ADDR_TX_DATA, 32'h33);
    reset = 1'b1; cyc(); reset = 1'b0;
    check("midrst_din_valid", uart_din_valid, 0);
    rd(ADDR_RX_CTRL, 32'd0, "midrst_rx_empty");
    rd(ADDR_TX_CTRL, 32'd1, "midrst_tx_free");

    repeat (2) cyc();
    checks++;
    if (exp_rd_q.size() != 0 || exp_tx_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d reads %0d tx pending expected 0",
               exp_rd_q.size(), exp_tx_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
